// File: rtl/ccp_pkg.sv
// Shared message encodings, field widths and helpers for the L1.5 crossbar and memory model.
package ccp_pkg;

    localparam int MSG_WIDTH  = 8;
    localparam int DATA_WIDTH = 64;
    localparam int TAG_WIDTH  = 5;
    localparam int MESI_WIDTH = 2;

    localparam logic [MSG_WIDTH-1:0] MSG_TYPE_EMPTY        = 8'd0;
    localparam logic [MSG_WIDTH-1:0] MSG_TYPE_LOAD_REQ     = 8'd31;
    localparam logic [MSG_WIDTH-1:0] MSG_TYPE_STORE_REQ    = 8'd2;
    localparam logic [MSG_WIDTH-1:0] MSG_TYPE_NODATA_ACK   = 8'd28;
    localparam logic [MSG_WIDTH-1:0] MSG_TYPE_DATA_ACK     = 8'd30;
    localparam logic [MSG_WIDTH-1:0] MSG_TYPE_INV_FWD      = 8'd16;
    localparam logic [MSG_WIDTH-1:0] MSG_TYPE_LOAD_MEM     = 8'd19;
    localparam logic [MSG_WIDTH-1:0] MSG_TYPE_STORE_MEM    = 8'd20;
    localparam logic [MSG_WIDTH-1:0] MSG_TYPE_LOAD_MEM_ACK = 8'd24;

    function automatic logic is_mem_req(input logic [MSG_WIDTH-1:0] msg_type);
        return (msg_type == MSG_TYPE_LOAD_MEM) || (msg_type == MSG_TYPE_STORE_MEM);
    endfunction

endpackage

// File: rtl/ccp_rr_arb.sv
// Round-robin arbiter: searches from the pointer upward with wrap, pointer moves past the winner on advance.
module ccp_rr_arb #(
    parameter int N     = 4,
    parameter int PTR_W = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     req,
    input  logic             advance,
    output logic [N-1:0]     grant,
    output logic [PTR_W-1:0] winner,
    output logic             any
);

    logic [PTR_W-1:0] ptr_reg;
    logic [PTR_W-1:0] ptr_next;

    always_comb begin
        any    = 1'b0;
        winner = '0;
        grant  = '0;
        for (int k = 0; k < N; k++) begin
            if (!any && req[(int'(ptr_reg) + k) % N]) begin
                any    = 1'b1;
                winner = PTR_W'((int'(ptr_reg) + k) % N);
            end
        end
        if (any) begin
            grant[winner] = 1'b1;
        end
    end

    always_comb begin
        ptr_next = ptr_reg;
        if (advance && any) begin
            ptr_next = (int'(winner) == N - 1) ? '0 : winner + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_reg <= '0;
        end else begin
            ptr_reg <= ptr_next;
        end
    end

endmodule

// File: rtl/l15_xbar_mem.sv
// N-core L1.5 crossbar with round-robin msg1/msg3 arbitration and a fixed-latency backing memory.
// Optional error status and request-stability checking: define CCP_XBAR_ERR_EN.
module l15_xbar_mem
    import ccp_pkg::*;
#(
    parameter int NUM_CORES   = 4,
    parameter int MEM_LATENCY = 2,
    parameter int MEM_DEPTH   = 32,
    localparam int SRC_W      = $clog2(NUM_CORES)
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [MSG_WIDTH-1:0]             msg2_type,
    input  logic [DATA_WIDTH-1:0]            msg2_data,
    input  logic [TAG_WIDTH-1:0]             msg2_tag,
    input  logic [TAG_WIDTH-1:0]             msg2_load_tag,
    input  logic [MESI_WIDTH-1:0]            mesi_send,
    input  logic [SRC_W-1:0]                 cache_owner,
    input  logic [NUM_CORES-1:0]             share_list,
    output logic                             msg2_ready,
    output logic [NUM_CORES*MSG_WIDTH-1:0]   core_msg2_type,
    output logic [NUM_CORES*DATA_WIDTH-1:0]  core_msg2_data,
    output logic [NUM_CORES*TAG_WIDTH-1:0]   core_msg2_tag,
    output logic [NUM_CORES*MESI_WIDTH-1:0]  core_msg2_mesi,
    input  logic [NUM_CORES*MSG_WIDTH-1:0]   core_msg1_type,
    input  logic [NUM_CORES*DATA_WIDTH-1:0]  core_msg1_data,
    input  logic [NUM_CORES*TAG_WIDTH-1:0]   core_msg1_tag,
    output logic [NUM_CORES-1:0]             core_msg1_grant,
    input  logic [NUM_CORES*MSG_WIDTH-1:0]   core_msg3_type,
    input  logic [NUM_CORES*DATA_WIDTH-1:0]  core_msg3_data,
    input  logic [NUM_CORES*TAG_WIDTH-1:0]   core_msg3_tag,
    output logic [NUM_CORES-1:0]             core_msg3_grant,
    output logic [MSG_WIDTH-1:0]             msg1_type,
    output logic [DATA_WIDTH-1:0]            msg1_data,
    output logic [TAG_WIDTH-1:0]             msg1_tag,
    output logic [SRC_W-1:0]                 msg1_source,
    input  logic                             msg1_ready,
    output logic [MSG_WIDTH-1:0]             msg3_type,
    output logic [DATA_WIDTH-1:0]            msg3_data,
    output logic [TAG_WIDTH-1:0]             msg3_tag,
    output logic [SRC_W-1:0]                 msg3_source,
    input  logic                             msg3_ready,
    output logic [1:0]                       err_status
);

    localparam int CNT_W = $clog2(MEM_LATENCY + 1);

    logic [MSG_WIDTH-1:0]  c1_type [NUM_CORES];
    logic [DATA_WIDTH-1:0] c1_data [NUM_CORES];
    logic [TAG_WIDTH-1:0]  c1_tag  [NUM_CORES];
    logic [MSG_WIDTH-1:0]  c3_type [NUM_CORES];
    logic [DATA_WIDTH-1:0] c3_data [NUM_CORES];
    logic [TAG_WIDTH-1:0]  c3_tag  [NUM_CORES];
    logic [NUM_CORES-1:0]  req1, req3, core_hit;

    logic inv_fwd, unicast;
    assign inv_fwd = (msg2_type == MSG_TYPE_INV_FWD);
    assign unicast = (msg2_type != MSG_TYPE_EMPTY) && !inv_fwd && !is_mem_req(msg2_type);

    // Owner comparison only matches real core indices, so out-of-range owners are dropped here.
    generate
        for (genvar gi = 0; gi < NUM_CORES; gi++) begin : g_core
            assign c1_type[gi] = core_msg1_type[gi*MSG_WIDTH +: MSG_WIDTH];
            assign c1_data[gi] = core_msg1_data[gi*DATA_WIDTH +: DATA_WIDTH];
            assign c1_tag[gi]  = core_msg1_tag[gi*TAG_WIDTH +: TAG_WIDTH];
            assign c3_type[gi] = core_msg3_type[gi*MSG_WIDTH +: MSG_WIDTH];
            assign c3_data[gi] = core_msg3_data[gi*DATA_WIDTH +: DATA_WIDTH];
            assign c3_tag[gi]  = core_msg3_tag[gi*TAG_WIDTH +: TAG_WIDTH];
            assign req1[gi]    = (c1_type[gi] != MSG_TYPE_EMPTY);
            assign req3[gi]    = (c3_type[gi] != MSG_TYPE_EMPTY);

            assign core_hit[gi] = inv_fwd ? share_list[gi]
                                          : (unicast && (cache_owner == SRC_W'(gi)));
            assign core_msg2_type[gi*MSG_WIDTH +: MSG_WIDTH]    = core_hit[gi] ? msg2_type : MSG_TYPE_EMPTY;
            assign core_msg2_data[gi*DATA_WIDTH +: DATA_WIDTH]  = core_hit[gi] ? msg2_data : '0;
            assign core_msg2_tag[gi*TAG_WIDTH +: TAG_WIDTH]     = core_hit[gi] ? msg2_tag  : '0;
            assign core_msg2_mesi[gi*MESI_WIDTH +: MESI_WIDTH]  = core_hit[gi] ? mesi_send : '0;
        end
    endgenerate

    // Backing memory and the single outstanding ACK
    logic [DATA_WIDTH-1:0] mem_reg [MEM_DEPTH];
    logic [DATA_WIDTH-1:0] ack_data_reg;
    logic [TAG_WIDTH-1:0]  ack_tag_reg;
    logic                  mem_pend_reg;
    logic [CNT_W-1:0]      cnt_reg;
    logic                  mem_accept, ack_eligible, ack_load;
    logic                  msg1_free, msg3_free, msg3_core_adv;

    assign msg2_ready   = !mem_pend_reg;
    assign mem_accept   = msg2_ready && is_mem_req(msg2_type);
    assign ack_eligible = mem_pend_reg && (cnt_reg == '0);
    assign ack_load     = msg3_free && ack_eligible;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < MEM_DEPTH; i++) begin
                mem_reg[i] <= '0;
            end
            ack_data_reg <= '0;
            ack_tag_reg  <= '0;
            mem_pend_reg <= 1'b0;
            cnt_reg      <= '0;
        end else if (mem_accept) begin
            ack_data_reg <= mem_reg[msg2_load_tag];
            ack_tag_reg  <= msg2_load_tag;
            mem_pend_reg <= 1'b1;
            cnt_reg      <= CNT_W'(MEM_LATENCY - 1);
            if (msg2_type == MSG_TYPE_STORE_MEM) begin
                mem_reg[msg2_tag] <= msg2_data;
            end
        end else begin
            if (ack_load) begin
                mem_pend_reg <= 1'b0;
            end
            if (mem_pend_reg && (cnt_reg != '0)) begin
                cnt_reg <= cnt_reg - 1'b1;
            end
        end
    end

    logic [NUM_CORES-1:0] grant1, grant3;
    logic [SRC_W-1:0]     win1, win3;
    logic                 any1, any3;

    assign msg1_free     = (msg1_type == MSG_TYPE_EMPTY) || msg1_ready;
    assign msg3_free     = (msg3_type == MSG_TYPE_EMPTY) || msg3_ready;
    assign msg3_core_adv = msg3_free && !ack_eligible;

    ccp_rr_arb #(.N(NUM_CORES)) u_arb1 (
        .clk     (clk),
        .rst     (rst),
        .req     (req1),
        .advance (msg1_free),
        .grant   (grant1),
        .winner  (win1),
        .any     (any1)
    );

    ccp_rr_arb #(.N(NUM_CORES)) u_arb3 (
        .clk     (clk),
        .rst     (rst),
        .req     (req3),
        .advance (msg3_core_adv),
        .grant   (grant3),
        .winner  (win3),
        .any     (any3)
    );

    assign core_msg1_grant = msg1_free ? grant1 : '0;
    assign core_msg3_grant = msg3_core_adv ? grant3 : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            msg1_type   <= MSG_TYPE_EMPTY;
            msg1_data   <= '0;
            msg1_tag    <= '0;
            msg1_source <= '0;
        end else if (msg1_free) begin
            msg1_type   <= any1 ? c1_type[win1] : MSG_TYPE_EMPTY;
            msg1_data   <= any1 ? c1_data[win1] : '0;
            msg1_tag    <= any1 ? c1_tag[win1]  : '0;
            msg1_source <= any1 ? win1          : '0;
        end
    end

    // Memory ACK takes priority over every core on msg3
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            msg3_type   <= MSG_TYPE_EMPTY;
            msg3_data   <= '0;
            msg3_tag    <= '0;
            msg3_source <= '0;
        end else if (msg3_free) begin
            if (ack_eligible) begin
                msg3_type   <= MSG_TYPE_LOAD_MEM_ACK;
                msg3_data   <= ack_data_reg;
                msg3_tag    <= ack_tag_reg;
                msg3_source <= '0;
            end else begin
                msg3_type   <= any3 ? c3_type[win3] : MSG_TYPE_EMPTY;
                msg3_data   <= any3 ? c3_data[win3] : '0;
                msg3_tag    <= any3 ? c3_tag[win3]  : '0;
                msg3_source <= any3 ? win3          : '0;
            end
        end
    end

`ifdef CCP_XBAR_ERR_EN
    logic [1:0] err_reg;
    logic       owner_oor;

    assign owner_oor  = unicast && (32'(cache_owner) >= 32'(NUM_CORES));
    assign err_status = err_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_reg <= '0;
        end else begin
            if (owner_oor) begin
                err_reg[0] <= 1'b1;
            end
            if (is_mem_req(msg2_type) && !msg2_ready) begin
                err_reg[1] <= 1'b1;
            end
        end
    end

    // A core that was requesting but not granted last cycle must present the identical request now.
    generate
        for (genvar gi = 0; gi < NUM_CORES; gi++) begin : g_stable
            logic                                      hold1_reg, hold3_reg;
            logic [MSG_WIDTH+DATA_WIDTH+TAG_WIDTH-1:0] prev1_reg, prev3_reg;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    hold1_reg <= 1'b0;
                    hold3_reg <= 1'b0;
                    prev1_reg <= '0;
                    prev3_reg <= '0;
                end else begin
                    assert (!hold1_reg || ({c1_type[gi], c1_data[gi], c1_tag[gi]} == prev1_reg))
                        else $error("core %0d msg1 request changed while ungranted", gi);
                    assert (!hold3_reg || ({c3_type[gi], c3_data[gi], c3_tag[gi]} == prev3_reg))
                        else $error("core %0d msg3 request changed while ungranted", gi);
                    hold1_reg <= req1[gi] && !core_msg1_grant[gi];
                    hold3_reg <= req3[gi] && !core_msg3_grant[gi];
                    prev1_reg <= {c1_type[gi], c1_data[gi], c1_tag[gi]};
                    prev3_reg <= {c3_type[gi], c3_data[gi], c3_tag[gi]};
                end
            end
        end
    endgenerate
`else
    assign err_status = '0;
`endif

endmodule

// File: tb/tb_l15_xbar_mem.sv
// Directed plus randomized bench for l15_xbar_mem against a cycle-level behavioural model.
module tb_l15_xbar_mem;
    import ccp_pkg::*;

    localparam int N = 4;
    localparam int L = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [7:0]    msg2_type;
    logic [63:0]   msg2_data;
    logic [4:0]    msg2_tag, msg2_load_tag;
    logic [1:0]    mesi_send;
    logic [1:0]    cache_owner;
    logic [N-1:0]  share_list;
    logic          msg2_ready;
    logic [N*8-1:0]  core_msg2_type;
    logic [N*64-1:0] core_msg2_data;
    logic [N*5-1:0]  core_msg2_tag;
    logic [N*2-1:0]  core_msg2_mesi;
    logic [N*8-1:0]  core_msg1_type, core_msg3_type;
    logic [N*64-1:0] core_msg1_data, core_msg3_data;
    logic [N*5-1:0]  core_msg1_tag, core_msg3_tag;
    logic [N-1:0]    core_msg1_grant, core_msg3_grant;
    logic [7:0]    msg1_type, msg3_type;
    logic [63:0]   msg1_data, msg3_data;
    logic [4:0]    msg1_tag, msg3_tag;
    logic [1:0]    msg1_source, msg3_source;
    logic          msg1_ready, msg3_ready;
    logic [1:0]    err_status;

    // Core request state per channel (0 = msg1, 1 = msg3); a core holds until granted
    logic [7:0]  rq_type [2][N];
    logic [63:0] rq_data [2][N];
    logic [4:0]  rq_tag  [2][N];

    for (genvar gi = 0; gi < N; gi++) begin : g_pack
        assign core_msg1_type[gi*8 +: 8]   = rq_type[0][gi];
        assign core_msg1_data[gi*64 +: 64] = rq_data[0][gi];
        assign core_msg1_tag[gi*5 +: 5]    = rq_tag[0][gi];
        assign core_msg3_type[gi*8 +: 8]   = rq_type[1][gi];
        assign core_msg3_data[gi*64 +: 64] = rq_data[1][gi];
        assign core_msg3_tag[gi*5 +: 5]    = rq_tag[1][gi];
    end

    l15_xbar_mem #(.NUM_CORES(N), .MEM_LATENCY(L), .MEM_DEPTH(32)) dut (
        .clk(clk), .rst(rst),
        .msg2_type(msg2_type), .msg2_data(msg2_data), .msg2_tag(msg2_tag),
        .msg2_load_tag(msg2_load_tag), .mesi_send(mesi_send), .cache_owner(cache_owner),
        .share_list(share_list), .msg2_ready(msg2_ready),
        .core_msg2_type(core_msg2_type), .core_msg2_data(core_msg2_data),
        .core_msg2_tag(core_msg2_tag), .core_msg2_mesi(core_msg2_mesi),
        .core_msg1_type(core_msg1_type), .core_msg1_data(core_msg1_data),
        .core_msg1_tag(core_msg1_tag), .core_msg1_grant(core_msg1_grant),
        .core_msg3_type(core_msg3_type), .core_msg3_data(core_msg3_data),
        .core_msg3_tag(core_msg3_tag), .core_msg3_grant(core_msg3_grant),
        .msg1_type(msg1_type), .msg1_data(msg1_data), .msg1_tag(msg1_tag),
        .msg1_source(msg1_source), .msg1_ready(msg1_ready),
        .msg3_type(msg3_type), .msg3_data(msg3_data), .msg3_tag(msg3_tag),
        .msg3_source(msg3_source), .msg3_ready(msg3_ready),
        .err_status(err_status)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state
    int          ptr [2];
    logic [7:0]  s_type [2];
    logic [63:0] s_data [2];
    logic [4:0]  s_tag  [2];
    int          s_src  [2];
    logic [63:0] mem_m [32];
    bit          pend;
    int          acc_cyc;
    int          cyc = 0;
    logic [63:0] ack_d;
    logic [4:0]  ack_t;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < 2; c++) begin
            ptr[c] = 0; s_type[c] = MSG_TYPE_EMPTY; s_data[c] = '0; s_tag[c] = '0; s_src[c] = 0;
            for (int i = 0; i < N; i++) begin
                rq_type[c][i] = MSG_TYPE_EMPTY; rq_data[c][i] = '0; rq_tag[c][i] = '0;
            end
        end
        for (int i = 0; i < 32; i++) mem_m[i] = '0;
        pend = 0;
        acc_cyc = 0;
    endtask

    // First requesting core at or after the pointer, cyclically; -1 if none
    function automatic int pick(input int ch);
        for (int k = 0; k < N; k++) begin
            if (rq_type[ch][(ptr[ch] + k) % N] != MSG_TYPE_EMPTY) return (ptr[ch] + k) % N;
        end
        return -1;
    endfunction

    task automatic route_check();
        logic [N*8-1:0] et;
        bit             tgt;
        et = '0;
        for (int i = 0; i < N; i++) begin
            tgt = 0;
            if (msg2_type == MSG_TYPE_INV_FWD) tgt = share_list[i];
            else if (msg2_type != MSG_TYPE_EMPTY && msg2_type != MSG_TYPE_LOAD_MEM &&
                     msg2_type != MSG_TYPE_STORE_MEM && int'(cache_owner) == i) tgt = 1;
            if (tgt) begin
                et[i*8 +: 8] = msg2_type;
                chk("route_data", core_msg2_data[i*64 +: 64], msg2_data);
                chk("route_mesi", {62'd0, core_msg2_mesi[i*2 +: 2]}, {62'd0, mesi_send});
            end
        end
        chk("route_type", {32'd0, core_msg2_type}, {32'd0, et});
    endtask

    task automatic new_req(input int ch, input int i);
        rq_type[ch][i] = 8'($urandom_range(1, 255));
        rq_data[ch][i] = {$urandom, $urandom};
        rq_tag[ch][i]  = 5'($urandom_range(0, 31));
    endtask

    // One clock: check combinational outputs, advance the model across the edge, check registered outputs
    task automatic cycle(input bit refill);
        int       w [2];
        bit       fr [2];
        bit       ackel, acc;
        logic [N-1:0] eg1, eg3;
        #1;
        route_check();
        w[0] = pick(0); w[1] = pick(1);
        fr[0] = (s_type[0] == MSG_TYPE_EMPTY) || msg1_ready;
        fr[1] = (s_type[1] == MSG_TYPE_EMPTY) || msg3_ready;
        ackel = pend && (cyc - acc_cyc >= L - 1);
        eg1 = '0; eg3 = '0;
        if (fr[0] && w[0] >= 0) eg1[w[0]] = 1'b1;
        if (fr[1] && !ackel && w[1] >= 0) eg3[w[1]] = 1'b1;
        chk("msg1_grant", {60'd0, core_msg1_grant}, {60'd0, eg1});
        chk("msg3_grant", {60'd0, core_msg3_grant}, {60'd0, eg3});
        chk("msg2_ready", {63'd0, msg2_ready}, {63'd0, !pend});
        acc = !pend && (msg2_type == MSG_TYPE_LOAD_MEM || msg2_type == MSG_TYPE_STORE_MEM);
        @(posedge clk);
        cyc++;
        #1;
        if (acc) begin
            ack_d = mem_m[msg2_load_tag];
            ack_t = msg2_load_tag;
            if (msg2_type == MSG_TYPE_STORE_MEM) mem_m[msg2_tag] = msg2_data;
            pend = 1;
            acc_cyc = cyc;
        end
        for (int c = 0; c < 2; c++) begin
            if (fr[c]) begin
                if (c == 1 && ackel) begin
                    s_type[1] = MSG_TYPE_LOAD_MEM_ACK; s_data[1] = ack_d; s_tag[1] = ack_t; s_src[1] = 0;
                    pend = 0;
                end else if (w[c] >= 0) begin
                    s_type[c] = rq_type[c][w[c]]; s_data[c] = rq_data[c][w[c]];
                    s_tag[c] = rq_tag[c][w[c]]; s_src[c] = w[c];
                    rq_type[c][w[c]] = MSG_TYPE_EMPTY;
                    ptr[c] = (w[c] + 1) % N;
                end else begin
                    s_type[c] = MSG_TYPE_EMPTY;
                end
            end
        end
        chk("msg1_type", {56'd0, msg1_type}, {56'd0, s_type[0]});
        chk("msg3_type", {56'd0, msg3_type}, {56'd0, s_type[1]});
        if (s_type[0] != MSG_TYPE_EMPTY) begin
            chk("msg1_data", msg1_data, s_data[0]);
            chk("msg1_tag_src", {57'd0, msg1_tag, msg1_source}, {57'd0, s_tag[0], 2'(s_src[0])});
        end
        if (s_type[1] != MSG_TYPE_EMPTY) begin
            chk("msg3_data", msg3_data, s_data[1]);
            chk("msg3_tag_src", {57'd0, msg3_tag, msg3_source}, {57'd0, s_tag[1], 2'(s_src[1])});
        end
        $display("cyc %0d g1=%b g3=%b msg1=%h/%0d msg3=%h/%0d pend=%0d",
                 cyc, eg1, eg3, msg1_type, msg1_source, msg3_type, msg3_source, pend);
        if (refill) begin
            for (int c = 0; c < 2; c++)
                for (int i = 0; i < N; i++)
                    if (rq_type[c][i] == MSG_TYPE_EMPTY && $urandom_range(0, 2) == 0) new_req(c, i);
        end
    endtask

    initial begin
        rst = 1'b1;
        msg2_type = MSG_TYPE_EMPTY; msg2_data = '0; msg2_tag = '0; msg2_load_tag = '0;
        mesi_send = '0; cache_owner = '0; share_list = '0;
        msg1_ready = 1'b1; msg3_ready = 1'b1;
        model_reset();
        #12;
        chk("rst_msg1_type", {56'd0, msg1_type}, {56'd0, MSG_TYPE_EMPTY});
        chk("rst_msg3_type", {56'd0, msg3_type}, {56'd0, MSG_TYPE_EMPTY});
        chk("rst_msg1_src", {62'd0, msg1_source}, 64'd0);
        chk("rst_msg2_ready", {63'd0, msg2_ready}, 64'd1);
        chk("rst_err", {62'd0, err_status}, 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // INV_FWD multicast by share list
        msg2_type = MSG_TYPE_INV_FWD; share_list = 4'b1010; msg2_data = 64'h1234;
        #1;
        chk("inv_core0", {56'd0, core_msg2_type[0 +: 8]},  {56'd0, MSG_TYPE_EMPTY});
        chk("inv_core1", {56'd0, core_msg2_type[8 +: 8]},  {56'd0, MSG_TYPE_INV_FWD});
        chk("inv_core2", {56'd0, core_msg2_type[16 +: 8]}, {56'd0, MSG_TYPE_EMPTY});
        chk("inv_core3", {56'd0, core_msg2_type[24 +: 8]}, {56'd0, MSG_TYPE_INV_FWD});
        cycle(0);
        msg2_type = MSG_TYPE_EMPTY;

        // All four cores request msg1 together
        for (int i = 0; i < N; i++) new_req(0, i);
        for (int k = 0; k < N; k++) begin
            cycle(0);
            chk("rr_seq_src", {62'd0, msg1_source}, 64'(k));
        end
        cycle(0);

        // Back-pressure on msg1 holds the slot and suppresses grants
        rq_type[0][2] = MSG_TYPE_LOAD_REQ; rq_data[0][2] = 64'hC0DE; rq_tag[0][2] = 5'd9;
        msg1_ready = 1'b0;
        cycle(0);
        new_req(0, 2); new_req(0, 0);
        for (int k = 0; k < 3; k++) begin
            cycle(0);
            chk("hold_src", {62'd0, msg1_source}, 64'd2);
            chk("hold_data", msg1_data, 64'hC0DE);
        end
        msg1_ready = 1'b1;
        for (int k = 0; k < 3; k++) cycle(0);

        // STORE_MEM then ACK racing two core msg3 requests
        msg2_type = MSG_TYPE_STORE_MEM; msg2_tag = 5'd5; msg2_data = 64'hAB; msg2_load_tag = 5'd5;
        cycle(0);
        msg2_type = MSG_TYPE_EMPTY;
        chk("mem_ready_low", {63'd0, msg2_ready}, 64'd0);
        cycle(0);
        new_req(1, 0); new_req(1, 1);
        cycle(0);
        chk("ack_type", {56'd0, msg3_type}, {56'd0, MSG_TYPE_LOAD_MEM_ACK});
        chk("ack_data", msg3_data, 64'h0);
        chk("ack_tag", {59'd0, msg3_tag}, 64'd5);
        cycle(0);
        chk("after_ack_src0", {62'd0, msg3_source}, 64'd0);
        cycle(0);
        chk("after_ack_src1", {62'd0, msg3_source}, 64'd1);
        msg2_type = MSG_TYPE_LOAD_MEM; msg2_load_tag = 5'd5; msg2_tag = 5'd5;
        cycle(0);
        msg2_type = MSG_TYPE_EMPTY;
        cycle(0); cycle(0);
        chk("reload_data", msg3_data, 64'hAB);

        // Randomized traffic on all channels
        for (int n = 0; n < 400; n++) begin
            case ($urandom_range(0, 5))
                0: msg2_type = MSG_TYPE_EMPTY;
                1: msg2_type = MSG_TYPE_INV_FWD;
                2: msg2_type = MSG_TYPE_LOAD_MEM;
                3: msg2_type = MSG_TYPE_STORE_MEM;
                4: msg2_type = MSG_TYPE_LOAD_REQ;
                default: msg2_type = MSG_TYPE_DATA_ACK;
            endcase
            msg2_data = {$urandom, $urandom};
            msg2_tag = 5'($urandom_range(0, 7));
            msg2_load_tag = 5'($urandom_range(0, 7));
            mesi_send = 2'($urandom);
            cache_owner = 2'($urandom);
            share_list = 4'($urandom);
            msg1_ready = ($urandom_range(0, 9) < 7);
            msg3_ready = ($urandom_range(0, 9) < 7);
            cycle(1);
        end

        // Asynchronous reset with msg1 full and a memory request pending
        msg2_type = MSG_TYPE_EMPTY; msg1_ready = 1'b1; msg3_ready = 1'b1;
        for (int k = 0; k < 20 && pend; k++) cycle(0);
        msg1_ready = 1'b0;
        if (rq_type[0][1] == MSG_TYPE_EMPTY) new_req(0, 1);
        msg2_type = MSG_TYPE_STORE_MEM; msg2_tag = 5'd3; msg2_data = 64'h55; msg2_load_tag = 5'd3;
        cycle(0);
        msg2_type = MSG_TYPE_EMPTY;
        #2;
        rst = 1'b1;
        #1;
        chk("arst_msg1_type", {56'd0, msg1_type}, {56'd0, MSG_TYPE_EMPTY});
        chk("arst_msg3_type", {56'd0, msg3_type}, {56'd0, MSG_TYPE_EMPTY});
        chk("arst_msg2_ready", {63'd0, msg2_ready}, 64'd1);
        model_reset();
        msg1_ready = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("post_rst_ready", {63'd0, msg2_ready}, 64'd1);
        msg2_type = MSG_TYPE_LOAD_MEM; msg2_load_tag = 5'd3;
        cycle(0);
        msg2_type = MSG_TYPE_EMPTY;
        cycle(0); cycle(0);
        chk("post_rst_mem", msg3_data, 64'h0);
        chk("post_rst_err", {62'd0, err_status}, 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
